// File: rtl/pll_seq_pkg.sv
// Shared types and default constants for the PLL lock sequencer.
package pll_seq_pkg;

  // Sequencer phases, encoded so the debug output reads 0..3 in order.
  typedef enum logic [1:0] {
    RST_PLL   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam int unsigned DEF_PLL_RST_CYCLES = 16;
  localparam int unsigned DEF_LOCK_CYCLES    = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT   = 65536;
  localparam int unsigned DEF_CE_DIV         = 8;
  localparam int unsigned DEF_CNT_W          = 4;

  // Largest of three cycle budgets; sizes the shared phase counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous status bit.
// All stages reset to 0 so a freshly reset consumer always sees "not ready".
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through STAGES flops; the last flop is the clean copy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock qualification sequencer.
// Holds the PLL in reset, waits for lock, qualifies it as stable for
// LOCK_CYCLES, then releases the core reset and runs a clock-enable divider.
// Lock loss in RUN restarts the whole sequence and is counted for debug.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,    // >= 2
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_CYCLES    = DEF_LOCK_CYCLES,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned CE_DIV         = DEF_CE_DIV,         // >= 2
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic             clear_lost,
  output logic             pll_rst,
  output logic             sys_reset,
  output logic             ce_pulse,
  output logic [1:0]       seq_state,
  output logic [CNT_W-1:0] lost_cnt
);

  localparam int unsigned CNT_MAX = max3(PLL_RST_CYCLES, LOCK_CYCLES, LOCK_TIMEOUT);
  localparam int unsigned CTR_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned DIV_W   = $clog2(CE_DIV);

  localparam logic [CTR_W-1:0] CNT_ONE   = CTR_W'(1);
  localparam logic [CTR_W-1:0] RST_LAST  = CTR_W'(PLL_RST_CYCLES - 1);
  localparam logic [CTR_W-1:0] TO_LAST   = CTR_W'(LOCK_TIMEOUT - 1);
  localparam logic [CTR_W-1:0] LOCK_LAST = CTR_W'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CE_DIV - 1);
  localparam logic [CNT_W-1:0] LOST_ONE  = CNT_W'(1);

  seq_state_t       state_q, state_d;
  logic [CTR_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] lost_q, lost_d;
  logic             pll_rst_q, sys_reset_q;
  logic             lk;

  // Bring the asynchronous lock flag into the clk_sys domain.
  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i  (clk_sys),
    .rst_ni (reset_n),
    .d_i    (pll_locked),
    .q_o    (lk)
  );

  // Next-state, shared phase counter, loss counter and divider.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    lost_d  = lost_q;
    div_d   = '0;

    unique case (state_q)
      RST_PLL: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lk)                    state_d = STABLE;
        else if (cnt_q == TO_LAST) state_d = RST_PLL;
      end
      STABLE: begin
        // A dropout before qualification completes is just another wait,
        // not a loss: the core never saw this clock.
        if (!lk)                     state_d = WAIT_LOCK;
        else if (cnt_q == LOCK_LAST) state_d = RUN;
      end
      RUN: begin
        cnt_d = '0;
        if (!lk) begin
          state_d = RST_PLL;
          if (lost_q != '1) lost_d = lost_q + LOST_ONE;
        end
      end
      default: state_d = RST_PLL;
    endcase

    // Every phase measures its own duration from zero.
    if (state_d != state_q) cnt_d = '0;

    // Clearing wins over a simultaneous loss increment.
    if (clear_lost) lost_d = '0;

    // Divider only advances while staying in RUN; it restarts at 0 on entry.
    if (state_q == RUN && state_d == RUN) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
    end
  end

  // State, counters and registered reset outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RST_PLL;
      cnt_q       <= '0;
      div_q       <= '0;
      lost_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      lost_q      <= lost_d;
      pll_rst_q   <= (state_d == RST_PLL);
      sys_reset_q <= (state_d != RUN);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_reset = sys_reset_q;
  // Only decoded from RUN, so it can never coincide with an asserted sys_reset.
  assign ce_pulse  = (state_q == RUN) && (div_q == DIV_LAST);
  assign seq_state = state_q;
  assign lost_cnt  = lost_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: phase/age model checked every cycle plus
// directed timing measurements with hand-computed expectations.
module tb_pll_lock_sequencer;

  localparam int SYNC     = 2;
  localparam int PRC      = 16;
  localparam int LC       = 1024;
  localparam int TO       = 4096;
  localparam int CED      = 8;
  localparam int CW       = 4;
  localparam int LOST_MAX = (1 << CW) - 1;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          pll_locked;
  logic          clear_lost;
  logic          pll_rst;
  logic          sys_reset;
  logic          ce_pulse;
  logic [1:0]    seq_state;
  logic [CW-1:0] lost_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  pll_lock_sequencer #(
    .SYNC_STAGES    (SYNC),
    .PLL_RST_CYCLES (PRC),
    .LOCK_CYCLES    (LC),
    .LOCK_TIMEOUT   (TO),
    .CE_DIV         (CED),
    .CNT_W          (CW)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .clear_lost (clear_lost),
    .pll_rst    (pll_rst),
    .sys_reset  (sys_reset),
    .ce_pulse   (ce_pulse),
    .seq_state  (seq_state),
    .lost_cnt   (lost_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Phase number plus time spent in the phase; lock seen SYNC cycles late.
  int m_phase = 0;
  int m_age   = 0;
  int m_lost  = 0;
  bit m_dly[SYNC];

  always @(posedge clk_sys or negedge reset_n) begin
    bit lk_seen;
    int nxt;
    if (!reset_n) begin
      m_phase = 0;
      m_age   = 0;
      m_lost  = 0;
      for (int i = 0; i < SYNC; i++) m_dly[i] = 1'b0;
    end else begin
      lk_seen = m_dly[SYNC-1];
      nxt     = m_phase;
      if (m_phase == 0 && m_age + 1 >= PRC)                 nxt = 1;
      else if (m_phase == 1 && lk_seen)                     nxt = 2;
      else if (m_phase == 1 && m_age + 1 >= TO)             nxt = 0;
      else if (m_phase == 2 && !lk_seen)                    nxt = 1;
      else if (m_phase == 2 && m_age + 1 >= LC)             nxt = 3;
      else if (m_phase == 3 && !lk_seen) begin
        nxt    = 0;
        m_lost = (m_lost + 1 > LOST_MAX) ? LOST_MAX : m_lost + 1;
      end
      if (clear_lost) m_lost = 0;
      m_age   = (nxt == m_phase) ? m_age + 1 : 0;
      m_phase = nxt;
      for (int i = SYNC - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
      m_dly[0] = pll_locked;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk_sys) begin
    if (reset_n) begin
      check("seq_state", seq_state, m_phase);
      check("pll_rst",   pll_rst,   m_phase == 0);
      check("sys_reset", sys_reset, m_phase != 3);
      check("ce_pulse",  ce_pulse,  (m_phase == 3) && ((m_age % CED) == CED - 1));
      check("lost_cnt",  lost_cnt,  m_lost);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_state(input int s, input int limit, input string name);
    int n;
    n = 0;
    while (seq_state !== 2'(s) && n < limit) begin
      tick();
      n++;
    end
    if (seq_state !== 2'(s)) check(name, seq_state, s);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n, m, w, first_low, rise, second_low, prev, sys_low, saw_wait;

    reset_n    = 1'b0;
    pll_locked = 1'b1;
    clear_lost = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_pll_rst",   pll_rst,   1);
    check("rst_sys_reset", sys_reset, 1);
    check("rst_ce_pulse",  ce_pulse,  0);
    check("rst_seq_state", seq_state, 0);
    check("rst_lost_cnt",  lost_cnt,  0);

    // 1: constant lock from reset release.
    reset_n   = 1'b1;
    n         = 0;
    first_low = 0;
    do begin
      tick();
      n++;
      if (!pll_rst && first_low == 0) first_low = n;
    end while (sys_reset && n < 3000);
    check("t1_pll_rst_cycles", first_low, 16);
    check("t1_release_cycle",  n,         16 + 1 + 1024);
    m = 1;
    while (!ce_pulse && m < 50) begin
      tick();
      m++;
    end
    check("t1_first_ce_run_cycle", m, 8);
    m = 0;
    do begin
      tick();
      m++;
    end while (!ce_pulse && m < 50);
    check("t1_ce_period", m, 8);

    // 2: no lock at all -> timeout and PLL reset re-pulse.
    @(negedge clk_sys);
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    @(negedge clk_sys);
    reset_n    = 1'b1;
    n = 0; first_low = 0; rise = 0; second_low = 0; sys_low = 0; prev = 1;
    repeat (PRC + TO + PRC + 2) begin
      tick();
      n++;
      if (!sys_reset) sys_low = 1;
      if (prev == 1 && !pll_rst && first_low == 0)                  first_low = n;
      else if (prev == 0 && pll_rst && rise == 0)                   rise = n;
      else if (prev == 1 && !pll_rst && rise != 0 && second_low == 0) second_low = n;
      prev = int'(pll_rst);
    end
    check("t2_first_pll_rst_low", first_low,  16);
    check("t2_timeout_repulse",   rise,       16 + 4096);
    check("t2_second_low",        second_low, 16 + 4096 + 16);
    check("t2_sys_reset_held",    sys_low,    0);
    check("t2_lost_cnt",          lost_cnt,   0);

    // 3: dropout during STABLE restarts qualification, not counted.
    @(negedge clk_sys);
    pll_locked = 1'b1;
    wait_state(2, 20, "t3_reach_stable");
    repeat (500) @(posedge clk_sys);
    @(negedge clk_sys);
    pll_locked = 1'b0;
    repeat (3) @(negedge clk_sys);
    pll_locked = 1'b1;
    n = 0;
    saw_wait = 0;
    do begin
      tick();
      n++;
      if (seq_state == 2'd1) saw_wait = 1;
    end while (sys_reset && n < 3000);
    check("t3_back_to_wait", saw_wait, 1);
    check("t3_requal_cycles", n, 2 + 1 + 1024);
    check("t3_lost_cnt", lost_cnt, 0);

    // 4: lock loss in RUN, then saturation over 20 losses.
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    pll_locked = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!sys_reset && n < 20);
    check("t4_sys_reset_latency", n, SYNC + 1);
    check("t4_ce_stopped", ce_pulse, 0);
    w = 0;
    while (pll_rst && w < 100) begin
      w++;
      tick();
    end
    check("t4_pll_rst_width", w, 16);
    check("t4_lost_first", lost_cnt, 1);
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk_sys);
      pll_locked = 1'b1;
      wait_state(3, 2000, "t4_reach_run");
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      pll_locked = 1'b0;
      wait_state(0, 10, "t4_reach_rst");
      check("t4_lost_sat", lost_cnt, (k > LOST_MAX) ? LOST_MAX : k);
    end

    // 5: clear_lost coincident with a RUN lock loss.
    @(negedge clk_sys);
    pll_locked = 1'b1;
    wait_state(3, 2000, "t5_reach_run");
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    pll_locked = 1'b0;
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    clear_lost = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    clear_lost = 1'b0;
    #1;
    check("t5_lost_cleared", lost_cnt, 0);
    check("t5_state_rst", seq_state, 0);

    // 6: asynchronous reset in the middle of RUN.
    @(negedge clk_sys);
    pll_locked = 1'b1;
    wait_state(3, 2000, "t6_reach_run1");
    @(negedge clk_sys);
    pll_locked = 1'b0;
    wait_state(0, 10, "t6_reach_rst");
    check("t6_lost_before", lost_cnt, 1);
    @(negedge clk_sys);
    pll_locked = 1'b1;
    wait_state(3, 2000, "t6_reach_run2");
    repeat (4) @(posedge clk_sys);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_sys_reset", sys_reset, 1);
    check("t6_pll_rst",   pll_rst,   1);
    check("t6_lost_cnt",  lost_cnt,  0);
    check("t6_seq_state", seq_state, 0);
    check("t6_ce_pulse",  ce_pulse,  0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (20) @(posedge clk_sys);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
